// File: rtl/mpu_viol_log.sv
// Violation log for the MPU: queues denied accesses in a first-word-fall-through
// FIFO, counts events lost to a full queue, and raises a level interrupt for the reader.
module mpu_viol_log #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 22,
  parameter int IRQ_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     viol_valid,
  input  logic [31:0]              viol_pc,
  input  logic [ADDR_W-1:0]        viol_addr,
  input  logic                     viol_wr,
  input  logic                     viol_inst,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_pc,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_wr,
  output logic                     rd_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  input  logic                     clr_ovf,
  output logic                     irq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(IRQ_THRESH);

  typedef struct packed {
    logic [31:0]       pc;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              inst;
  } entry_t;

  entry_t mem [DEPTH];
  entry_t entry_in;
  entry_t head;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             full;
  logic             push;
  logic             pop;
  logic             drop;
  logic [CNT_W-1:0] count_next;
  logic             overflow_next;
  logic [15:0]      drop_cnt_next;
  logic             irq_next;

  assign entry_in = '{pc: viol_pc, addr: viol_addr, wr: viol_wr, inst: viol_inst};

  // Head is read straight out of storage so the oldest entry falls through to rd_*.
  assign head     = mem[rd_ptr];
  assign rd_pc    = head.pc;
  assign rd_addr  = head.addr;
  assign rd_wr    = head.wr;
  assign rd_inst  = head.inst;
  assign rd_valid = (count != '0);

  always_comb begin
    full = (count == DEPTH_C);
    pop  = rd_valid && rd_ready;
    push = viol_valid && (!full || pop);
    drop = viol_valid && full && !pop;

    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase

    // A drop wins over a coincident clear so the lost event is always recorded.
    overflow_next = overflow;
    drop_cnt_next = drop_cnt;
    if (drop) begin
      overflow_next = 1'b1;
      if (clr_ovf) begin
        drop_cnt_next = 16'd1;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt_next = drop_cnt + 16'd1;
      end
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
      drop_cnt_next = 16'd0;
    end

    irq_next = (count_next >= THRESH_C) || overflow_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
      irq      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_next;
      overflow <= overflow_next;
      drop_cnt <= drop_cnt_next;
      irq      <= irq_next;
    end
  end

  // Storage has no reset; a write is suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

endmodule

// File: tb/tb_mpu_viol_log.sv
// Bench for mpu_viol_log: a reference model plus scoreboard queue of expected
// entries, exercised by one task per scenario.
module tb_mpu_viol_log;

  typedef struct packed {
    logic [31:0] pc;
    logic [21:0] addr;
    logic        wr;
    logic        inst;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        viol_valid;
  logic [31:0] viol_pc;
  logic [21:0] viol_addr;
  logic        viol_wr;
  logic        viol_inst;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [21:0] rd_addr;
  logic        rd_wr;
  logic        rd_inst;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_ovf;
  logic        irq;

  exp_t        sb[$];
  exp_t        exp_head;
  bit          exp_popped;
  int          m_count;
  logic        m_ovf;
  logic [15:0] m_drop;
  logic        m_irq;
  int          n_checks;
  int          n_pass;

  mpu_viol_log #(.DEPTH(8), .ADDR_W(22), .IRQ_THRESH(4)) dut (
    .clk(clk), .resetn(resetn),
    .viol_valid(viol_valid), .viol_pc(viol_pc), .viol_addr(viol_addr),
    .viol_wr(viol_wr), .viol_inst(viol_inst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_addr(rd_addr),
    .rd_wr(rd_wr), .rd_inst(rd_inst),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
    .clr_ovf(clr_ovf), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one cycle of inputs and advances the model to its post-edge state.
  task automatic applyStimulus(input logic vv, input logic [31:0] pc, input logic [21:0] addr,
                               input logic wr, input logic inst, input logic rr, input logic clr);
    bit   mpop, mpush, mdrop;
    exp_t e;
    viol_valid = vv; viol_pc = pc; viol_addr = addr; viol_wr = wr; viol_inst = inst;
    rd_ready = rr; clr_ovf = clr;
    mpop  = rr && (m_count != 0);
    mpush = vv && ((m_count < 8) || mpop);
    mdrop = vv && !mpush;
    exp_popped = mpop;
    if (mpop) exp_head = sb.pop_front();
    if (mpush) begin
      e.pc = pc; e.addr = addr; e.wr = wr; e.inst = inst;
      sb.push_back(e);
    end
    m_count = m_count + (mpush ? 1 : 0) - (mpop ? 1 : 0);
    if (mdrop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 16'd1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 16'd0;
    end
    m_irq = (m_count >= 4) || m_ovf;
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0; m_ovf = 1'b0; m_drop = 16'd0; m_irq = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    applyStimulus(0, 32'h0, 22'h0, 0, 0, 0, 0);
    model_reset();
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    n_checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); else n_pass++;
    n_checks++; if (count !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", irq); else n_pass++;
  endtask

  task automatic test_single();
    applyStimulus(1, 32'h0000_0040, 22'h300, 1, 0, 0, 0);
    n_checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL single_no_bypass: got rd_valid=%b expected 0", rd_valid); else n_pass++;
    tick();
    applyStimulus(0, 32'h0, 22'h0, 0, 0, 0, 0);
    n_checks++; if (rd_valid !== 1'b1) $display("[TB] FAIL single_rd_valid: got %b expected 1", rd_valid); else n_pass++;
    n_checks++; if (rd_pc !== 32'h40 || rd_addr !== 22'h300 || rd_wr !== 1'b1 || rd_inst !== 1'b0)
      $display("[TB] FAIL single_head: got pc=%h addr=%h wr=%b inst=%b expected pc=40 addr=300 wr=1 inst=0", rd_pc, rd_addr, rd_wr, rd_inst);
    else n_pass++;
    n_checks++; if (count !== 4'(m_count)) $display("[TB] FAIL single_count: got %0d expected %0d", count, m_count); else n_pass++;
    applyStimulus(0, 32'h0, 22'h0, 0, 0, 1, 0);
    n_checks++; if (!exp_popped || rd_pc !== exp_head.pc || rd_addr !== exp_head.addr)
      $display("[TB] FAIL single_pop: got pc=%h addr=%h expected pc=%h addr=%h", rd_pc, rd_addr, exp_head.pc, exp_head.addr);
    else n_pass++;
    tick();
    n_checks++; if (count !== 4'd0 || rd_valid !== 1'b0) $display("[TB] FAIL single_empty: got count=%0d rd_valid=%b expected 0 0", count, rd_valid); else n_pass++;
  endtask

  task automatic test_threshold_fill();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 32'h10 + 32'(4 * i), 22'h100 + 22'(i), 1'(i), 1'(i >> 1), 0, 0);
      tick();
      n_checks++; if (irq !== m_irq) $display("[TB] FAIL fill_irq_%0d: got %b expected %b", i, irq, m_irq); else n_pass++;
    end
    applyStimulus(0, 32'h0, 22'h0, 0, 0, 0, 0);
    n_checks++; if (count !== 4'd8) $display("[TB] FAIL fill_count: got %0d expected 8", count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL fill_overflow: got %b expected 0", overflow); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h30 + 32'(4 * i), 22'h3FF, 0, 1, 0, 0);
      tick();
    end
    applyStimulus(0, 32'h0, 22'h0, 0, 0, 0, 0);
    n_checks++; if (count !== 4'd8) $display("[TB] FAIL ovf_count: got %0d expected 8", count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd3) $display("[TB] FAIL ovf_drop_cnt: got %0d expected 3", drop_cnt); else n_pass++;
    n_checks++; if (rd_pc !== 32'h10) $display("[TB] FAIL ovf_head: got %h expected 10", rd_pc); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 32'h0, 22'h0, 0, 0, 1, 0);
      n_checks++; if (!exp_popped || rd_pc !== exp_head.pc || rd_addr !== exp_head.addr || rd_wr !== exp_head.wr || rd_inst !== exp_head.inst)
        $display("[TB] FAIL ovf_pop_%0d: got pc=%h addr=%h wr=%b inst=%b expected pc=%h addr=%h wr=%b inst=%b",
                 i, rd_pc, rd_addr, rd_wr, rd_inst, exp_head.pc, exp_head.addr, exp_head.wr, exp_head.inst);
      else n_pass++;
      tick();
      n_checks++; if (irq !== 1'b1) $display("[TB] FAIL ovf_irq_held_%0d: got %b expected 1", i, irq); else n_pass++;
    end
    applyStimulus(0, 32'h0, 22'h0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 32'h0, 22'h0, 0, 0, 0, 0);
    n_checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0 || irq !== 1'b0)
      $display("[TB] FAIL ovf_clear: got overflow=%b drop_cnt=%0d irq=%b expected 0 0 0", overflow, drop_cnt, irq);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 32'h200 + 32'(i), 22'h2000 + 22'(i), 0, 1'(i), 0, 0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'h100 + 32'(i), 22'h3F000 + 22'(i), 1'(i), 1'(i >> 1), 1, 0);
      n_checks++; if (!exp_popped || rd_pc !== exp_head.pc || rd_addr !== exp_head.addr || rd_wr !== exp_head.wr || rd_inst !== exp_head.inst)
        $display("[TB] FAIL pp_pop_%0d: got pc=%h addr=%h expected pc=%h addr=%h", i, rd_pc, rd_addr, exp_head.pc, exp_head.addr);
      else n_pass++;
      tick();
      n_checks++; if (count !== 4'd8 || drop_cnt !== m_drop)
        $display("[TB] FAIL pp_count_%0d: got count=%0d drop_cnt=%0d expected 8 %0d", i, count, drop_cnt, m_drop);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 32'h0, 22'h0, 0, 0, 1, 0);
      n_checks++; if (!exp_popped || rd_pc !== exp_head.pc || rd_addr !== exp_head.addr || rd_wr !== exp_head.wr || rd_inst !== exp_head.inst)
        $display("[TB] FAIL pp_drain_%0d: got pc=%h addr=%h expected pc=%h addr=%h", i, rd_pc, rd_addr, exp_head.pc, exp_head.addr);
      else n_pass++;
      if (i == 7) begin
        n_checks++; if (rd_pc !== 32'h113) $display("[TB] FAIL pp_last_out: got %h expected 113", rd_pc); else n_pass++;
      end
      tick();
    end
    n_checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL pp_empty: got rd_valid=%b expected 0", rd_valid); else n_pass++;
  endtask

  task automatic test_clr_with_drop();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1, 32'h400 + 32'(i), 22'h55 + 22'(i), 0, 0, 0, 0);
      tick();
    end
    n_checks++; if (drop_cnt !== 16'd5) $display("[TB] FAIL cd_preload: got %0d expected 5", drop_cnt); else n_pass++;
    applyStimulus(1, 32'h500, 22'h66, 1, 0, 0, 1);
    tick();
    n_checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1)
      $display("[TB] FAIL cd_result: got overflow=%b drop_cnt=%0d expected 1 1", overflow, drop_cnt);
    else n_pass++;
  endtask

  task automatic test_saturate_and_reset();
    while (m_drop != 16'hFFFE) begin
      applyStimulus(1, 32'h600, 22'h77, 0, 0, 0, 0);
      tick();
    end
    n_checks++; if (drop_cnt !== 16'hFFFE) $display("[TB] FAIL sat_pre: got %h expected FFFE", drop_cnt); else n_pass++;
    applyStimulus(1, 32'h600, 22'h77, 0, 0, 0, 0);
    tick();
    n_checks++; if (drop_cnt !== 16'hFFFF) $display("[TB] FAIL sat_reach: got %h expected FFFF", drop_cnt); else n_pass++;
    repeat (3) begin
      applyStimulus(1, 32'h600, 22'h77, 0, 0, 0, 0);
      tick();
    end
    n_checks++; if (drop_cnt !== 16'hFFFF || count !== 4'd8)
      $display("[TB] FAIL sat_hold: got drop_cnt=%h count=%0d expected FFFF 8", drop_cnt, count);
    else n_pass++;
    n_checks++; if (rd_pc !== sb[0].pc) $display("[TB] FAIL sat_oldest_kept: got %h expected %h", rd_pc, sb[0].pc); else n_pass++;

    // Reset with a push and a pop pending: everything must be discarded.
    resetn = 1'b0;
    applyStimulus(1, 32'h700, 22'h88, 1, 1, 1, 0);
    model_reset();
    tick();
    resetn = 1'b1;
    applyStimulus(0, 32'h0, 22'h0, 0, 0, 0, 0);
    n_checks++; if (count !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 16'd0 || irq !== 1'b0)
      $display("[TB] FAIL midreset: got count=%0d rd_valid=%b overflow=%b drop_cnt=%0d irq=%b expected all 0",
               count, rd_valid, overflow, drop_cnt, irq);
    else n_pass++;
    applyStimulus(1, 32'h800, 22'h99, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 32'h0, 22'h0, 0, 0, 0, 0);
    n_checks++; if (rd_valid !== 1'b1 || rd_pc !== 32'h800 || rd_inst !== 1'b1 || count !== 4'd1)
      $display("[TB] FAIL post_reset_push: got rd_valid=%b pc=%h inst=%b count=%0d expected 1 800 1 1", rd_valid, rd_pc, rd_inst, count);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    resetn = 1'b0; viol_valid = 1'b0; viol_pc = '0; viol_addr = '0;
    viol_wr = 1'b0; viol_inst = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    exp_popped = 1'b0; exp_head = '0;
    model_reset();
    test_reset();
    test_single();
    test_threshold_fill();
    test_overflow();
    test_full_push_pop();
    test_clr_with_drop();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
